axi_tdd_ng_sync_gen_mc: RTL and testbench

Multi-channel TDD synchronisation pulse generator for the axi_tdd_ng core. A common start event (software or edge-detected external sync) launches NUM_CH independent channels. Each channel emits single-cycle pulses at a programmable phase offset and period, for a bounded or unbounded burst. It sits between the register map and the TDD counter/channel logic and replaces the single-channel, free-running internal sync source.

---
 rtl/axi_tdd_ng_pkg.sv | 5 +
 rtl/axi_tdd_ng_sync_ch.sv | 96 +++++++++
 rtl/axi_tdd_ng_sync_gen_mc.sv | 72 +++++++
 tb/tb_axi_tdd_ng_sync_gen_mc.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/axi_tdd_ng_pkg.sv
// axi_tdd_ng_pkg: channel state type and synchroniser depth shared by the TDD sync generator
package axi_tdd_ng_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, OFFSET, RUN, DONE} ch_state_t;
    localparam int SYNC_CDC_STAGES = 3;
endpackage

// File: rtl/axi_tdd_ng_sync_ch.sv
// axi_tdd_ng_sync_ch: one sync channel FSM; offset phase then periodic pulses for a bounded or unbounded burst
// Ports: clk, resetn (sync, active-low); start (registered common start event);
//        enable (global & channel enable); offset/period/burst (sampled at start);
//        sync_out (registered pulse), active (OFFSET or RUN), done (burst completed)
module axi_tdd_ng_sync_ch
    import axi_tdd_ng_pkg::*;
#(
    parameter int SYNC_COUNT_WIDTH = 32,
    parameter int BURST_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        enable,
    input  logic [SYNC_COUNT_WIDTH-1:0] offset,
    input  logic [SYNC_COUNT_WIDTH-1:0] period,
    input  logic [BURST_WIDTH-1:0]      burst,
    output logic                        sync_out,
    output logic                        active,
    output logic                        done
);
    ch_state_t                   st, st_n;
    logic [SYNC_COUNT_WIDTH-1:0] cnt, cnt_n, off, off_n, per, per_n;
    logic [BURST_WIDTH-1:0]      pc, pc_n, bur, bur_n;
    logic                        fire_n;

    // per holds the latched period-1, so a period of 0 or 1 both wrap every cycle.
    // Outputs are registered from the next-state values, so each output matches
    // the state the channel occupies in the same cycle.
    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        off_n = off;
        per_n = per;
        pc_n  = pc;
        bur_n = bur;
        if (!enable) begin
            st_n = IDLE;
        end else if (start && st != IDLE) begin
            st_n  = OFFSET;
            cnt_n = '0;
            pc_n  = '0;
            off_n = offset;
            per_n = (period == '0) ? '0 : period - SYNC_COUNT_WIDTH'(1);
            bur_n = burst;
        end else begin
            case (st)
                IDLE: st_n = ARMED;
                OFFSET: begin
                    if (cnt == off) begin
                        cnt_n = '0;
                        pc_n  = BURST_WIDTH'(1);
                        st_n  = (bur == BURST_WIDTH'(1)) ? DONE : RUN;
                    end else begin
                        cnt_n = cnt + SYNC_COUNT_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (cnt == per) begin
                        cnt_n = '0;
                        pc_n  = pc + BURST_WIDTH'(1);
                        st_n  = (bur != '0 && pc_n == bur) ? DONE : RUN;
                    end else begin
                        cnt_n = cnt + SYNC_COUNT_WIDTH'(1);
                    end
                end
                default: st_n = st;
            endcase
        end
        fire_n = (st_n == OFFSET && cnt_n == off_n) || (st_n == RUN && cnt_n == per_n);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st       <= IDLE;
            cnt      <= '0;
            off      <= '0;
            per      <= '0;
            pc       <= '0;
            bur      <= '0;
            sync_out <= 1'b0;
            active   <= 1'b0;
            done     <= 1'b0;
        end else begin
            st       <= st_n;
            cnt      <= cnt_n;
            off      <= off_n;
            per      <= per_n;
            pc       <= pc_n;
            bur      <= bur_n;
            sync_out <= fire_n;
            active   <= (st_n == OFFSET) || (st_n == RUN);
            done     <= (st_n == DONE);
        end
    end
endmodule

// File: rtl/axi_tdd_ng_sync_gen_mc.sv
// axi_tdd_ng_sync_gen_mc: multi-channel TDD sync pulse generator launched by a common soft/external start
// Ports: clk, resetn (sync, active-low); sync_in (external sync level); tdd_enable;
//        tdd_sync_ext (allow external edge); tdd_sync_soft (soft start pulse);
//        ch_enable/ch_offset/ch_period/ch_burst (per-channel config, flattened);
//        sync_out, ch_active, ch_done (per-channel status)
// Build option: AXI_TDD_NG_SYNC_CDC_EN adds a 3-flop synchroniser on sync_in.
module axi_tdd_ng_sync_gen_mc
    import axi_tdd_ng_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int SYNC_COUNT_WIDTH = 32,
    parameter int BURST_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               sync_in,
    input  logic                               tdd_enable,
    input  logic                               tdd_sync_ext,
    input  logic                               tdd_sync_soft,
    input  logic [NUM_CH-1:0]                  ch_enable,
    input  logic [NUM_CH*SYNC_COUNT_WIDTH-1:0] ch_offset,
    input  logic [NUM_CH*SYNC_COUNT_WIDTH-1:0] ch_period,
    input  logic [NUM_CH*BURST_WIDTH-1:0]      ch_burst,
    output logic [NUM_CH-1:0]                  sync_out,
    output logic [NUM_CH-1:0]                  ch_active,
    output logic [NUM_CH-1:0]                  ch_done
);
    logic ext_edge, start_r;

`ifdef AXI_TDD_NG_SYNC_CDC_EN
    logic [SYNC_CDC_STAGES-1:0] m;

    always_ff @(posedge clk) begin
        if (!resetn) m <= '0;
        else         m <= {m[SYNC_CDC_STAGES-2:0], sync_in};
    end

    assign ext_edge = m[SYNC_CDC_STAGES-2] & ~m[SYNC_CDC_STAGES-1];
`else
    logic sync_in_d;

    always_ff @(posedge clk) begin
        if (!resetn) sync_in_d <= 1'b0;
        else         sync_in_d <= sync_in;
    end

    assign ext_edge = sync_in & ~sync_in_d;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) start_r <= 1'b0;
        else         start_r <= tdd_sync_soft | (tdd_sync_ext & ext_edge);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        axi_tdd_ng_sync_ch #(
            .SYNC_COUNT_WIDTH(SYNC_COUNT_WIDTH),
            .BURST_WIDTH     (BURST_WIDTH)
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .start   (start_r),
            .enable  (tdd_enable & ch_enable[i]),
            .offset  (ch_offset[i*SYNC_COUNT_WIDTH +: SYNC_COUNT_WIDTH]),
            .period  (ch_period[i*SYNC_COUNT_WIDTH +: SYNC_COUNT_WIDTH]),
            .burst   (ch_burst[i*BURST_WIDTH +: BURST_WIDTH]),
            .sync_out(sync_out[i]),
            .active  (ch_active[i]),
            .done    (ch_done[i])
        );
    end
endmodule

// File: tb/tb_axi_tdd_ng_sync_gen_mc.sv
// tb_axi_tdd_ng_sync_gen_mc: table-driven check of pulse timing, burst, retrigger, external start and reset
module tb_axi_tdd_ng_sync_gen_mc;
    localparam int N = 4;
    localparam int W = 32;
    localparam int B = 16;
`ifdef AXI_TDD_NG_SYNC_CDC_EN
    localparam int XL = 2;
`else
    localparam int XL = 0;
`endif

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           sync_in = 1'b0;
    logic           tdd_enable = 1'b0;
    logic           tdd_sync_ext = 1'b0;
    logic           tdd_sync_soft = 1'b0;
    logic [N-1:0]   ch_enable = '0;
    logic [N*W-1:0] ch_offset = '0;
    logic [N*W-1:0] ch_period = '0;
    logic [N*B-1:0] ch_burst = '0;
    logic [N-1:0]   sync_out, ch_active, ch_done;

    int checks = 0;
    int failures = 0;

    axi_tdd_ng_sync_gen_mc #(.NUM_CH(N), .SYNC_COUNT_WIDTH(W), .BURST_WIDTH(B)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sync_in      (sync_in),
        .tdd_enable   (tdd_enable),
        .tdd_sync_ext (tdd_sync_ext),
        .tdd_sync_soft(tdd_sync_soft),
        .ch_enable    (ch_enable),
        .ch_offset    (ch_offset),
        .ch_period    (ch_period),
        .ch_burst     (ch_burst),
        .sync_out     (sync_out),
        .ch_active    (ch_active),
        .ch_done      (ch_done)
    );

    always #5 clk = ~clk;

    // src: 0 soft start, 1 external edge with tdd_sync_ext=1, 2 external edge with tdd_sync_ext=0
    // re: relative cycle of a second soft start (-1 none); act_from/done_at: -1 means never
    typedef struct {
        int          ch;
        int          src;
        logic [31:0] off;
        logic [31:0] per;
        logic [15:0] bur;
        int          re;
        logic [31:0] mask;
        int          act_from;
        int          done_at;
    } vec_t;

    vec_t v[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int r, input logic [N-1:0] a, input logic [N-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s rel=%0d actual=%b expected=%b", nm, r, a, e);
        end
    endtask

    initial begin
        v[0] = '{0, 0, 32'd0, 32'd4, 16'd3, -1, 32'h0000_0444, 2, 11};
        v[1] = '{1, 0, 32'd5, 32'd1, 16'd0, -1, 32'hFFFF_FF80, 2, -1};
        v[2] = '{2, 0, 32'd2, 32'd0, 16'd2, -1, 32'h0000_0030, 2, 6};
        v[3] = '{3, 0, 32'd3, 32'd5, 16'd0, -1, 32'h4210_8420, 2, -1};
        v[4] = '{0, 0, 32'd1, 32'd2, 16'd1, -1, 32'h0000_0008, 2, 4};
        v[5] = '{1, 0, 32'd0, 32'd1, 16'd4, -1, 32'h0000_003C, 2, 6};
        v[6] = '{0, 0, 32'd0, 32'd10, 16'd0, 15, 32'h0802_1004, 2, -1};
        v[7] = '{0, 1, 32'd0, 32'd3, 16'd1, -1, 32'h0000_0004 << XL, 2 + XL, 3 + XL};
        v[8] = '{0, 2, 32'd0, 32'd3, 16'd1, -1, 32'h0000_0000, -1, -1};

        repeat (3) tick();
        @(negedge clk);
        chk("rst_sync_out", 0, sync_out, '0);
        chk("rst_active", 0, ch_active, '0);
        chk("rst_done", 0, ch_done, '0);
        tick();
        resetn = 1'b1;
        tdd_enable = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            ch_enable = '0;
            tdd_sync_ext = (v[i].src == 1);
            tick();
            tick();
            ch_offset[v[i].ch*W +: W] = v[i].off;
            ch_period[v[i].ch*W +: W] = v[i].per;
            ch_burst[v[i].ch*B +: B]  = v[i].bur;
            ch_enable = N'(1) << v[i].ch;
            tick();
            tick();
            if (v[i].src == 0) tdd_sync_soft = 1'b1;
            else sync_in = 1'b1;
            for (int r = 0; r < 32; r++) begin
                @(negedge clk);
                chk($sformatf("v%0d_sync_out", i), r, sync_out, v[i].mask[r] ? N'(1) << v[i].ch : '0);
                chk($sformatf("v%0d_active", i), r, ch_active,
                    (v[i].act_from >= 0 && r >= v[i].act_from && (v[i].done_at < 0 || r < v[i].done_at)) ? N'(1) << v[i].ch : '0);
                chk($sformatf("v%0d_done", i), r, ch_done,
                    (v[i].done_at >= 0 && r >= v[i].done_at) ? N'(1) << v[i].ch : '0);
                tick();
                tdd_sync_soft = (r + 1 == v[i].re);
                if (r + 1 == 20) sync_in = 1'b0;
            end
            ch_enable = '0;
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_off_sync_out", i), 33, sync_out, '0);
            chk($sformatf("v%0d_off_active", i), 33, ch_active, '0);
            chk($sformatf("v%0d_off_done", i), 33, ch_done, '0);
        end

        tdd_sync_ext = 1'b0;
        ch_offset[0 +: W] = 32'd0;
        ch_period[0 +: W] = 32'd1;
        ch_burst[0 +: B]  = 16'd0;
        ch_enable = 4'b0001;
        tick();
        tick();
        tdd_sync_soft = 1'b1;
        tick();
        tdd_sync_soft = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("run_sync_out", 0, sync_out, 4'b0001);
        chk("run_active", 0, ch_active, 4'b0001);
        tick();
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("rstrun_sync_out", 1, sync_out, '0);
        chk("rstrun_active", 1, ch_active, '0);
        chk("rstrun_done", 1, ch_done, '0);
        ch_enable = '0;
        tick();
        resetn = 1'b1;
        tick();
        tdd_sync_soft = 1'b1;
        tick();
        tdd_sync_soft = 1'b0;
        ch_enable = 4'b0001;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            chk("idle_start_sync_out", r, sync_out, '0);
            chk("idle_start_active", r, ch_active, '0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
